// File: rtl/branch_redirect_ctrl.sv
// Fetch/branch-hazard sequencer: tracks unresolved branch PCs in a small FIFO,
// throttles fetch when full and sequences redirect + flush on a mispredict.
module branch_redirect_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_INFLIGHT = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              fetch_valid,
    input  logic                              fetch_is_branch,
    input  logic [ADDR_WIDTH-1:0]             fetch_pc,
    input  logic                              resolve_valid,
    input  logic                              resolve_mispredict,
    input  logic [ADDR_WIDTH-1:0]             resolve_target,
    output logic                              stall_fetch,
    output logic                              flush,
    output logic                              redirect_valid,
    output logic [ADDR_WIDTH-1:0]             redirect_pc,
    output logic                              head_valid,
    output logic [ADDR_WIDTH-1:0]             head_pc,
    output logic [$clog2(MAX_INFLIGHT+1)-1:0] inflight,
    output logic                              err
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int PTR_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] mem_q [MAX_INFLIGHT];
    logic [PTR_W-1:0]      rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0]      wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [FC_W-1:0]       flushCnt_q;
    logic                  flush_q;
    logic                  redirectValid_q;
    logic [ADDR_WIDTH-1:0] redirectPc_q;
    logic                  err_q;

    logic mispredictNow;
    logic isFull;
    logic push;
    logic pop;

    assign mispredictNow = resolve_valid && resolve_mispredict;
    assign isFull        = (count_q == CNT_W'(MAX_INFLIGHT));
    assign stall_fetch   = (state_q == FLUSH) || isFull;
    assign push          = fetch_valid && fetch_is_branch && !stall_fetch &&
                           (state_q == RUN) && !mispredictNow;
    assign pop           = resolve_valid && (state_q == RUN) && (count_q != '0);

    // Pointers wrap explicitly so a non-power-of-two depth still works.
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (pop) begin
            rdPtr_d = (rdPtr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        if (push) begin
            wrPtr_d = (wrPtr_q == PTR_W'(MAX_INFLIGHT - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= RUN;
            rdPtr_q         <= '0;
            wrPtr_q         <= '0;
            count_q         <= '0;
            flushCnt_q      <= '0;
            flush_q         <= 1'b0;
            redirectValid_q <= 1'b0;
            redirectPc_q    <= '0;
            err_q           <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            redirectValid_q <= 1'b0;
            if (push) begin
                mem_q[wrPtr_q] <= fetch_pc;
            end
            case (state_q)
                RUN: begin
                    if (resolve_valid && (count_q == '0)) begin
                        err_q <= 1'b1;
                    end
                    // A mispredict squashes everything in flight, including this cycle's fetch.
                    if (mispredictNow) begin
                        redirectValid_q <= 1'b1;
                        redirectPc_q    <= resolve_target;
                        flush_q         <= 1'b1;
                        rdPtr_q         <= '0;
                        wrPtr_q         <= '0;
                        count_q         <= '0;
                        flushCnt_q      <= FC_W'(FLUSH_CYCLES - 1);
                        state_q         <= FLUSH;
                    end else begin
                        rdPtr_q <= rdPtr_d;
                        wrPtr_q <= wrPtr_d;
                        count_q <= count_d;
                    end
                end
                FLUSH: begin
                    if (flushCnt_q == '0) begin
                        flush_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        flushCnt_q <= flushCnt_q - 1'b1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign flush          = flush_q;
    assign redirect_valid = redirectValid_q;
    assign redirect_pc    = redirectPc_q;
    assign head_valid     = (count_q != '0);
    assign head_pc        = mem_q[rdPtr_q];
    assign inflight       = count_q;
    assign err            = err_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl; a queue of expected branch PCs
// is the scoreboard and is compared against head_pc/inflight as branches resolve.
module tb_branch_redirect_ctrl;

    localparam int AW    = 32;
    localparam int MAXI  = 2;
    localparam int FLUSH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fetch_valid = 1'b0;
    logic          fetch_is_branch = 1'b0;
    logic [AW-1:0] fetch_pc = '0;
    logic          resolve_valid = 1'b0;
    logic          resolve_mispredict = 1'b0;
    logic [AW-1:0] resolve_target = '0;
    logic          stall_fetch;
    logic          flush;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          head_valid;
    logic [AW-1:0] head_pc;
    logic [1:0]    inflight;
    logic          err;

    int            checks = 0;
    int            passes = 0;
    logic [AW-1:0] expQ[$];
    int            flushLeft = 0;

    branch_redirect_ctrl #(
        .ADDR_WIDTH  (AW),
        .MAX_INFLIGHT(MAXI),
        .FLUSH_CYCLES(FLUSH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fetch_valid       (fetch_valid),
        .fetch_is_branch   (fetch_is_branch),
        .fetch_pc          (fetch_pc),
        .resolve_valid     (resolve_valid),
        .resolve_mispredict(resolve_mispredict),
        .resolve_target    (resolve_target),
        .stall_fetch       (stall_fetch),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .head_valid        (head_valid),
        .head_pc           (head_pc),
        .inflight          (inflight),
        .err               (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Drives one cycle of stimulus, updates the expected-PC queue, returns 1ns after the edge.
    task automatic drive(input logic fv, input logic fb, input logic [AW-1:0] fpc,
                         input logic rv, input logic rm, input logic [AW-1:0] rt);
        bit inRun;
        bit stallM;
        fetch_valid        = fv;
        fetch_is_branch    = fb;
        fetch_pc           = fpc;
        resolve_valid      = rv;
        resolve_mispredict = rm;
        resolve_target     = rt;
        inRun  = (flushLeft == 0);
        stallM = !inRun || (expQ.size() == MAXI);
        if (inRun) begin
            if (rv && rm) begin
                expQ.delete();
                flushLeft = FLUSH;
            end else begin
                if (rv && expQ.size() > 0) void'(expQ.pop_front());
                if (fv && fb && !stallM) expQ.push_back(fpc);
            end
        end else begin
            flushLeft--;
        end
        @(posedge clk);
        #1;
        fetch_valid        = 1'b0;
        fetch_is_branch    = 1'b0;
        fetch_pc           = '0;
        resolve_valid      = 1'b0;
        resolve_mispredict = 1'b0;
        resolve_target     = '0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (stall_fetch !== 1'b0) $display("[TB] FAIL reset_stall got %0b want 0", stall_fetch); else passes++;
        checks++; if (flush !== 1'b0) $display("[TB] FAIL reset_flush got %0b want 0", flush); else passes++;
        checks++; if (redirect_valid !== 1'b0) $display("[TB] FAIL reset_redirect got %0b want 0", redirect_valid); else passes++;
        checks++; if (inflight !== 2'd0) $display("[TB] FAIL reset_inflight got %0d want 0", inflight); else passes++;
        checks++; if (head_valid !== 1'b0) $display("[TB] FAIL reset_head_valid got %0b want 0", head_valid); else passes++;
        checks++; if (err !== 1'b0) $display("[TB] FAIL reset_err got %0b want 0", err); else passes++;
        checks++; if (head_pc !== 32'h0) $display("[TB] FAIL reset_head_pc got %h want 0", head_pc); else passes++;
        checks++; if (redirect_pc !== 32'h0) $display("[TB] FAIL reset_redirect_pc got %h want 0", redirect_pc); else passes++;
    endtask

    task automatic test_fill();
        drive(1, 1, 32'h100, 0, 0, 0);
        checks++; if (inflight !== 2'(expQ.size())) $display("[TB] FAIL fill1_inflight got %0d want %0d", inflight, expQ.size()); else passes++;
        checks++; if (head_pc !== 32'h100) $display("[TB] FAIL fill1_head got %h want 100", head_pc); else passes++;
        checks++; if (stall_fetch !== 1'b0) $display("[TB] FAIL fill1_stall got %0b want 0", stall_fetch); else passes++;
        drive(1, 1, 32'h104, 0, 0, 0);
        checks++; if (inflight !== 2'd2) $display("[TB] FAIL fill2_inflight got %0d want 2", inflight); else passes++;
        checks++; if (stall_fetch !== 1'b1) $display("[TB] FAIL fill2_stall got %0b want 1", stall_fetch); else passes++;
        checks++; if (head_pc !== expQ[0]) $display("[TB] FAIL fill2_head got %h want %h", head_pc, expQ[0]); else passes++;
        drive(1, 1, 32'h108, 0, 0, 0);
        checks++; if (inflight !== 2'd2) $display("[TB] FAIL full_nopush_inflight got %0d want 2", inflight); else passes++;
        checks++; if (head_pc !== 32'h100) $display("[TB] FAIL full_nopush_head got %h want 100", head_pc); else passes++;
    endtask

    task automatic test_resolve();
        checks++; if (head_pc !== expQ[0]) $display("[TB] FAIL resolve_pre_head got %h want %h", head_pc, expQ[0]); else passes++;
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (inflight !== 2'd1) $display("[TB] FAIL resolve_inflight got %0d want 1", inflight); else passes++;
        checks++; if (head_pc !== 32'h104) $display("[TB] FAIL resolve_head got %h want 104", head_pc); else passes++;
        checks++; if (stall_fetch !== 1'b0) $display("[TB] FAIL resolve_stall got %0b want 0", stall_fetch); else passes++;
        checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) $display("[TB] FAIL resolve_noflush got %0b%0b want 00", flush, redirect_valid); else passes++;
    endtask

    task automatic test_back_to_back();
        checks++; if (head_pc !== expQ[0]) $display("[TB] FAIL b2b_pre_head got %h want %h", head_pc, expQ[0]); else passes++;
        drive(1, 1, 32'h108, 1, 0, 0);
        checks++; if (inflight !== 2'(expQ.size())) $display("[TB] FAIL b2b_inflight got %0d want %0d", inflight, expQ.size()); else passes++;
        checks++; if (head_pc !== 32'h108) $display("[TB] FAIL b2b_head got %h want 108", head_pc); else passes++;
    endtask

    task automatic test_mispredict();
        drive(1, 1, 32'h300, 1, 1, 32'h200);
        checks++; if (redirect_valid !== 1'b1) $display("[TB] FAIL mis_redirect got %0b want 1", redirect_valid); else passes++;
        checks++; if (redirect_pc !== 32'h200) $display("[TB] FAIL mis_redirect_pc got %h want 200", redirect_pc); else passes++;
        checks++; if (flush !== 1'b1 || stall_fetch !== 1'b1) $display("[TB] FAIL mis_flush1 got %0b%0b want 11", flush, stall_fetch); else passes++;
        checks++; if (inflight !== 2'd0) $display("[TB] FAIL mis_inflight got %0d want 0", inflight); else passes++;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (redirect_valid !== 1'b0) $display("[TB] FAIL mis_pulse got %0b want 0", redirect_valid); else passes++;
        checks++; if (flush !== 1'b1 || stall_fetch !== 1'b1) $display("[TB] FAIL mis_flush2 got %0b%0b want 11", flush, stall_fetch); else passes++;
        checks++; if (redirect_pc !== 32'h200) $display("[TB] FAIL mis_pc_hold got %h want 200", redirect_pc); else passes++;
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (flush !== 1'b0 || stall_fetch !== 1'b0) $display("[TB] FAIL mis_end got %0b%0b want 00", flush, stall_fetch); else passes++;
        checks++; if (inflight !== 2'd0 || head_valid !== 1'b0) $display("[TB] FAIL mis_nopush got %0d/%0b want 0/0", inflight, head_valid); else passes++;
    endtask

    task automatic test_flush_resolve_and_err();
        drive(1, 1, 32'h400, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 32'h500);
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (inflight !== 2'd0 || err !== 1'b0) $display("[TB] FAIL flushres_state got %0d/%0b want 0/0", inflight, err); else passes++;
        checks++; if (flush !== 1'b1) $display("[TB] FAIL flushres_flush got %0b want 1", flush); else passes++;
        drive(0, 0, 0, 1, 1, 32'h600);
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h500) $display("[TB] FAIL flushres_noredirect got %0b/%h want 0/500", redirect_valid, redirect_pc); else passes++;
        checks++; if (flush !== 1'b0 || err !== 1'b0) $display("[TB] FAIL flushres_exit got %0b/%0b want 0/0", flush, err); else passes++;
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (err !== 1'b1) $display("[TB] FAIL err_set got %0b want 1", err); else passes++;
        checks++; if (inflight !== 2'd0) $display("[TB] FAIL err_inflight got %0d want 0", inflight); else passes++;
        drive(1, 1, 32'h610, 0, 0, 0);
        checks++; if (head_pc !== expQ[0]) $display("[TB] FAIL err_traffic_head got %h want %h", head_pc, expQ[0]); else passes++;
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (err !== 1'b1) $display("[TB] FAIL err_sticky got %0b want 1", err); else passes++;
        drive(0, 0, 0, 1, 1, 32'hA00);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hA00) $display("[TB] FAIL err_mis_redirect got %0b/%h want 1/a00", redirect_valid, redirect_pc); else passes++;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        checks++; if (flush !== 1'b0 || err !== 1'b1) $display("[TB] FAIL err_mis_end got %0b/%0b want 0/1", flush, err); else passes++;
    endtask

    task automatic test_async_reset();
        drive(1, 1, 32'h700, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 32'h800);
        #2;
        reset = 1'b0;
        expQ.delete();
        flushLeft = 0;
        #1;
        checks++; if (flush !== 1'b0 || redirect_valid !== 1'b0) $display("[TB] FAIL arst_flush got %0b%0b want 00", flush, redirect_valid); else passes++;
        checks++; if (inflight !== 2'd0 || stall_fetch !== 1'b0) $display("[TB] FAIL arst_inflight got %0d/%0b want 0/0", inflight, stall_fetch); else passes++;
        checks++; if (err !== 1'b0 || redirect_pc !== 32'h0) $display("[TB] FAIL arst_regs got %0b/%h want 0/0", err, redirect_pc); else passes++;
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1, 32'h900, 0, 0, 0);
        checks++; if (inflight !== 2'd1 || head_pc !== 32'h900) $display("[TB] FAIL arst_after got %0d/%h want 1/900", inflight, head_pc); else passes++;
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (inflight !== 2'(expQ.size())) $display("[TB] FAIL arst_drain got %0d want %0d", inflight, expQ.size()); else passes++;
    endtask

    task automatic test_wrap();
        logic [AW-1:0] pc;
        drive(1, 1, 32'h10, 0, 0, 0);
        for (int i = 2; i <= 5; i++) begin
            pc = AW'(i * 16);
            checks++; if (head_pc !== expQ[0]) $display("[TB] FAIL wrap_head%0d got %h want %h", i, head_pc, expQ[0]); else passes++;
            drive(1, 1, pc, 1, 0, 0);
            checks++; if (inflight !== 2'(expQ.size())) $display("[TB] FAIL wrap_inflight%0d got %0d want %0d", i, inflight, expQ.size()); else passes++;
        end
        checks++; if (head_pc !== 32'h50) $display("[TB] FAIL wrap_last_head got %h want 50", head_pc); else passes++;
        drive(0, 0, 0, 1, 0, 0);
        checks++; if (inflight !== 2'd0 || head_valid !== 1'b0) $display("[TB] FAIL wrap_empty got %0d/%0b want 0/0", inflight, head_valid); else passes++;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_resolve();
        test_back_to_back();
        test_mispredict();
        test_flush_resolve_and_err();
        test_async_reset();
        test_wrap();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
